// File: rtl/mpmc11_chan_sched.sv
// Channel scheduler for the MPMC per-channel read-command FIFOs: two-class
// round-robin with anti-starvation promotion, one-cycle read strobe, grant held until done.
package mpmc11_pkg;
  typedef enum logic [2:0] {IDLE, INIT, CALIB, READ, WRITE, REFRESH} mpmc11_state_t;
endpackage

module mpmc11_chan_sched #(
  parameter int NCHAN      = 8,
  parameter int STARVE_LIM = 7
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  mpmc11_pkg::mpmc11_state_t  state,
  input  logic                       calib_complete,
  input  logic [NCHAN-1:0]           empty,
  input  logic [NCHAN-1:0]           rd_rst_busy,
  input  logic [NCHAN-1:0]           hipri,
  input  logic                       done,
  output logic [NCHAN-1:0]           rd,
  output logic [$clog2(NCHAN)-1:0]   ch,
  output logic                       cmd_valid,
  output logic                       busy
);

  localparam int CW = $clog2(NCHAN);
  localparam int WW = $clog2(STARVE_LIM + 1);

  typedef enum logic [1:0] {S_IDLE, S_POP, S_LAT, S_BUSY} fsm_t;

  fsm_t             fsm;
  logic [CW-1:0]    rr_ptr;
  logic [WW-1:0]    wait_cnt [NCHAN];

  logic [NCHAN-1:0] elig;
  logic [NCHAN-1:0] starve;
  logic [NCHAN-1:0] cls_mask;
  logic [CW-1:0]    gsel;
  logic             found;
  logic [CW:0]      pos;

  assign elig = ~empty & ~rd_rst_busy;

  always_comb begin
    starve = '0;
    for (int unsigned i = 0; i < NCHAN; i++)
      starve[i] = elig[i] && (wait_cnt[i] == WW'(STARVE_LIM));
  end

  // Highest non-empty class wins; round-robin applies only within that class.
  always_comb begin
    if (|starve)
      cls_mask = starve;
    else if (|(elig & hipri))
      cls_mask = elig & hipri;
    else
      cls_mask = elig;
  end

  always_comb begin
    found = 1'b0;
    gsel  = '0;
    pos   = '0;
    for (int unsigned k = 0; k < NCHAN; k++) begin
      pos = {1'b0, rr_ptr} + (CW+1)'(k);
      if (pos >= (CW+1)'(NCHAN))
        pos = pos - (CW+1)'(NCHAN);
      if (!found && cls_mask[pos[CW-1:0]]) begin
        found = 1'b1;
        gsel  = pos[CW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= S_IDLE;
      rd        <= '0;
      ch        <= '0;
      cmd_valid <= 1'b0;
      busy      <= 1'b0;
      rr_ptr    <= '0;
      for (int unsigned i = 0; i < NCHAN; i++)
        wait_cnt[i] <= '0;
    end else begin
      rd        <= '0;
      cmd_valid <= 1'b0;
      unique case (fsm)
        S_IDLE: begin
          if (state == mpmc11_pkg::IDLE && calib_complete && found) begin
            rd     <= NCHAN'(1) << gsel;
            ch     <= gsel;
            busy   <= 1'b1;
            fsm    <= S_POP;
            rr_ptr <= (gsel == CW'(NCHAN-1)) ? '0 : gsel + 1'b1;
            for (int unsigned i = 0; i < NCHAN; i++) begin
              if (CW'(i) == gsel)
                wait_cnt[i] <= '0;
              else if (!elig[i])
                wait_cnt[i] <= '0;
              else if (wait_cnt[i] != WW'(STARVE_LIM))
                wait_cnt[i] <= wait_cnt[i] + 1'b1;
            end
          end
        end
        S_POP: begin
          if (!calib_complete) begin
            busy <= 1'b0;
            fsm  <= S_IDLE;
          end else begin
            cmd_valid <= 1'b1;
            fsm       <= S_LAT;
          end
        end
        S_LAT: begin
          if (!calib_complete || done) begin
            busy <= 1'b0;
            fsm  <= S_IDLE;
          end else begin
            fsm <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (!calib_complete || done) begin
            busy <= 1'b0;
            fsm  <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mpmc11_chan_sched.sv
// Self-checking bench for mpmc11_chan_sched against a transaction-level arbitration model.
module tb_mpmc11_chan_sched;
  localparam int NCH = 8;
  localparam int LIM = 7;

  logic                      clk;
  logic                      rst_n;
  mpmc11_pkg::mpmc11_state_t state;
  logic                      calib_complete;
  logic [NCH-1:0]            empty;
  logic [NCH-1:0]            rd_rst_busy;
  logic [NCH-1:0]            hipri;
  logic                      done;
  logic [NCH-1:0]            rd;
  logic [2:0]                ch;
  logic                      cmd_valid;
  logic                      busy;

  int n_cmp = 0;
  int n_err = 0;

  int wait_m [NCH];
  int rr_m;

  mpmc11_chan_sched #(.NCHAN(NCH), .STARVE_LIM(LIM)) dut (
    .clk(clk), .rst_n(rst_n), .state(state), .calib_complete(calib_complete),
    .empty(empty), .rd_rst_busy(rd_rst_busy), .hipri(hipri), .done(done),
    .rd(rd), .ch(ch), .cmd_valid(cmd_valid), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) wait_m[i] = 0;
    rr_m = 0;
  endfunction

  // Class order: starving, then high priority, then everyone; cyclic from rr_m.
  function automatic int model_pick(input logic [NCH-1:0] e, input logic [NCH-1:0] h);
    logic [NCH-1:0] cls [3];
    logic [NCH-1:0] m;
    for (int i = 0; i < NCH; i++) cls[0][i] = e[i] && (wait_m[i] == LIM);
    cls[1] = e & h;
    cls[2] = e;
    for (int c = 0; c < 3; c++) begin
      m = cls[c];
      for (int k = 0; k < NCH; k++)
        if (m[(rr_m + k) % NCH]) return (rr_m + k) % NCH;
    end
    return -1;
  endfunction

  function automatic void model_grant(input int g, input logic [NCH-1:0] e);
    for (int i = 0; i < NCH; i++) begin
      if (i == g)     wait_m[i] = 0;
      else if (e[i])  wait_m[i] = (wait_m[i] + 1 > LIM) ? LIM : wait_m[i] + 1;
      else            wait_m[i] = 0;
    end
    rr_m = (g + 1) % NCH;
  endfunction

  function automatic logic [NCH-1:0] cur_elig();
    return ~empty & ~rd_rst_busy;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    state = mpmc11_pkg::IDLE;
    calib_complete = 1'b1;
    empty = '1;
    rd_rst_busy = '0;
    hipri = '0;
    done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Inputs for the arbitration must already be applied; ends in S_IDLE at a negedge.
  task automatic txn(input int g, input int dly, input bit scramble, input string nm);
    logic [NCH-1:0] exp_rd;
    exp_rd = '0;
    if (g >= 0) exp_rd[g] = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({rd, ch, busy, cmd_valid} !== {exp_rd, 3'(g), 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL %s strobe: rd=%h ch=%0d busy=%b cv=%b, expected rd=%h ch=%0d busy=1 cv=0",
               nm, rd, ch, busy, cmd_valid, exp_rd, g);
    end
    if (scramble) begin
      rd_rst_busy = NCH'($urandom);
      empty = NCH'($urandom);
      state = mpmc11_pkg::READ;
    end
    @(negedge clk);
    n_cmp++;
    if ({rd, ch, busy, cmd_valid} !== {{NCH{1'b0}}, 3'(g), 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL %s cmd_valid: rd=%h ch=%0d busy=%b cv=%b, expected rd=0 ch=%0d busy=1 cv=1",
               nm, rd, ch, busy, cmd_valid, g);
    end
    for (int d = 0; d < dly; d++) begin
      @(negedge clk);
      n_cmp++;
      if ({rd, ch, busy, cmd_valid} !== {{NCH{1'b0}}, 3'(g), 1'b1, 1'b0}) begin
        n_err++;
        $display("FAIL %s hold: rd=%h ch=%0d busy=%b cv=%b, expected rd=0 ch=%0d busy=1 cv=0",
                 nm, rd, ch, busy, cmd_valid, g);
      end
    end
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    n_cmp++;
    if ({rd, busy, cmd_valid} !== {{NCH{1'b0}}, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL %s release: rd=%h busy=%b cv=%b, expected rd=0 busy=0 cv=0",
               nm, rd, busy, cmd_valid);
    end
    if (scramble) state = mpmc11_pkg::IDLE;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({rd, ch, busy, cmd_valid} !== '0) begin
      n_err++;
      $display("FAIL reset_state: rd=%h ch=%0d busy=%b cv=%b, expected all 0", rd, ch, busy, cmd_valid);
    end
    apply_reset();
    n_cmp++;
    if ({rd, ch, busy, cmd_valid} !== '0) begin
      n_err++;
      $display("FAIL reset_hold: rd=%h ch=%0d busy=%b cv=%b, expected all 0", rd, ch, busy, cmd_valid);
    end
    empty = 8'hFE;
    txn(0, 2, 1'b0, "first_grant");
    model_grant(0, 8'h01);
  endtask

  task automatic test_calib_gate();
    int g;
    calib_complete = 1'b0;
    empty = 8'h00;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      n_cmp++;
      if (rd !== '0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL calib_gate: rd=%h busy=%b, expected rd=0 busy=0", rd, busy);
      end
    end
    calib_complete = 1'b1;
    g = model_pick(cur_elig(), hipri);
    txn(g, 1, 1'b0, "calib_raise");
    model_grant(g, 8'hFF);
  endtask

  task automatic test_state_gate();
    int g;
    empty = 8'h00;
    state = mpmc11_pkg::REFRESH;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (rd !== '0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL state_gate: rd=%h busy=%b, expected rd=0 busy=0", rd, busy);
      end
    end
    state = mpmc11_pkg::IDLE;
    g = model_pick(cur_elig(), hipri);
    txn(g, 0, 1'b0, "state_raise");
    model_grant(g, 8'hFF);
  endtask

  task automatic test_round_robin();
    apply_reset();
    empty = '0;
    hipri = '0;
    for (int k = 0; k < 9; k++) begin
      txn(k % NCH, 3, 1'b0, "round_robin");
      model_grant(k % NCH, 8'hFF);
    end
  endtask

  task automatic test_priority();
    int exp_seq [9] = '{7, 7, 7, 7, 7, 7, 7, 0, 1};
    apply_reset();
    empty = '0;
    hipri = 8'h80;
    for (int k = 0; k < 9; k++) begin
      txn(exp_seq[k], 1, 1'b0, "priority");
      model_grant(exp_seq[k], 8'hFF);
    end
    hipri = '0;
  endtask

  task automatic test_abort();
    int g;
    logic [NCH-1:0] e;
    e = cur_elig();
    g = model_pick(e, hipri);
    @(negedge clk);
    n_cmp++;
    if (rd !== NCH'(1) << g) begin
      n_err++;
      $display("FAIL abort_grant: rd=%h, expected %h", rd, NCH'(1) << g);
    end
    model_grant(g, e);
    @(negedge clk);
    @(negedge clk);
    calib_complete = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy, cmd_valid, rd} !== '0) begin
      n_err++;
      $display("FAIL abort_busy: busy=%b cv=%b rd=%h, expected all 0", busy, cmd_valid, rd);
    end
    @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy, cmd_valid, rd} !== '0) begin
      n_err++;
      $display("FAIL abort_done_ignored: busy=%b cv=%b rd=%h, expected all 0", busy, cmd_valid, rd);
    end
    // Abort while the strobe is out: the strobe stands, cmd_valid never appears.
    calib_complete = 1'b1;
    e = cur_elig();
    g = model_pick(e, hipri);
    @(negedge clk);
    n_cmp++;
    if (rd !== NCH'(1) << g || busy !== 1'b1) begin
      n_err++;
      $display("FAIL abort_pop_grant: rd=%h busy=%b, expected rd=%h busy=1", rd, busy, NCH'(1) << g);
    end
    model_grant(g, e);
    calib_complete = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({busy, cmd_valid, rd} !== '0) begin
        n_err++;
        $display("FAIL abort_pop: busy=%b cv=%b rd=%h, expected all 0", busy, cmd_valid, rd);
      end
    end
    calib_complete = 1'b1;
    g = model_pick(cur_elig(), hipri);
    txn(g, 2, 1'b0, "after_abort");
    model_grant(g, cur_elig());
  endtask

  task automatic test_async_reset();
    empty = '0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || $countones(rd) != 1) begin
      n_err++;
      $display("FAIL async_pre: rd=%h busy=%b, expected one-hot rd busy=1", rd, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({rd, busy, cmd_valid} !== '0) begin
      n_err++;
      $display("FAIL async_reset: rd=%h busy=%b cv=%b, expected all 0", rd, busy, cmd_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    txn(0, 1, 1'b0, "post_reset");
    model_grant(0, 8'hFF);
  endtask

  task automatic test_random();
    logic [NCH-1:0] e;
    int g;
    int b;
    for (int it = 0; it < 40; it++) begin
      empty = NCH'($urandom);
      rd_rst_busy = NCH'($urandom) & NCH'($urandom);
      hipri = NCH'($urandom);
      if (cur_elig() == '0) begin
        @(negedge clk);
        n_cmp++;
        if (rd !== '0 || busy !== 1'b0) begin
          n_err++;
          $display("FAIL no_elig: rd=%h busy=%b, expected rd=0 busy=0", rd, busy);
        end
        b = $urandom_range(NCH-1, 0);
        empty[b] = 1'b0;
        rd_rst_busy[b] = 1'b0;
      end
      e = cur_elig();
      g = model_pick(e, hipri);
      txn(g, $urandom_range(3, 0), 1'($urandom_range(1, 0)), "random");
      model_grant(g, e);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    state = mpmc11_pkg::IDLE;
    calib_complete = 1'b0;
    empty = '1;
    rd_rst_busy = '0;
    hipri = '0;
    done = 1'b0;
    model_reset();
    test_reset();
    test_calib_gate();
    test_state_gate();
    test_round_robin();
    test_priority();
    test_abort();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
